// File: rtl/gtrg_hdr_seq_if.sv
// Header word stream from gtrg_hdr_seq to the DMB packer.
// Valid/ready handshake: a word transfers on the clock where HDR_DV and HDR_RDY are both high.
interface gtrg_hdr_seq_if;
    logic [15:0] HDR_DATA;
    logic        HDR_DV;
    logic        HDR_LAST;
    logic        HDR_RDY;

    modport master (output HDR_DATA, output HDR_DV, output HDR_LAST, input HDR_RDY);
    modport slave  (input HDR_DATA, input HDR_DV, input HDR_LAST, output HDR_RDY);
endinterface

// File: rtl/gtrg_hdr_seq.sv
// GTRG FIFO consumer: pops one event, emits the four-word DMB header, then
// enables payload readout of the reporting sources until done or timeout.
module gtrg_hdr_seq #(
    parameter int unsigned L1CNT_W  = 24,
    parameter int unsigned TOUT_CYC = 4095
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               L1ARST,
    input  logic               EMPTY_B,
    input  logic [16:0]        DAVSOUT,
    input  logic [11:0]        BXCOUNTOUT,
    input  logic [3:0]         CFEBBX,
    gtrg_hdr_seq_if.master     hdr,
    input  logic               PAYDONE,
    output logic               POP,
    output logic [4:0]         CFEB_RDEN,
    output logic               TMB_RDEN,
    output logic               ALCT_RDEN,
    output logic               BUSY,
    output logic [L1CNT_W-1:0] L1ACNT,
    output logic               TOUT
);

    localparam logic [11:0] TOUT_LIM = 12'(TOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_H1,
        S_H2,
        S_H3,
        S_H4,
        S_PAYLOAD
    } state_t;

    state_t               state;
    logic [L1CNT_W-1:0]   l1a_cnt;
    logic [L1CNT_W-1:0]   l1a_lat;
    logic [L1CNT_W-1:0]   l1a_inc;
    logic [4:0]           cfeb_lat;
    logic                 tmb_lat;
    logic                 alct_lat;
    logic                 movlp_lat;
    logic [11:0]          bx_lat;
    logic [3:0]           cfebbx_lat;
    logic [11:0]          tcnt;
    logic [15:0]          hdr_data;
    logic                 hdr_dv;
    logic                 hdr_last;
    logic                 unused_lct;

    // LCT 5bx OR bits are not part of the header or readout enables.
    assign unused_lct = ^DAVSOUT[15:11];

    // A coincident L1ARST forces the value taken into the header to zero.
    always_comb begin
        l1a_inc = L1ARST ? '0 : l1a_cnt + L1CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            l1a_cnt    <= '0;
            l1a_lat    <= '0;
            cfeb_lat   <= '0;
            tmb_lat    <= 1'b0;
            alct_lat   <= 1'b0;
            movlp_lat  <= 1'b0;
            bx_lat     <= '0;
            cfebbx_lat <= '0;
            tcnt       <= '0;
            hdr_data   <= '0;
            hdr_dv     <= 1'b0;
            hdr_last   <= 1'b0;
            POP        <= 1'b0;
            CFEB_RDEN  <= '0;
            TMB_RDEN   <= 1'b0;
            ALCT_RDEN  <= 1'b0;
            TOUT       <= 1'b0;
        end else begin
            if (L1ARST) begin
                l1a_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (EMPTY_B) begin
                        state <= S_LATCH;
                        POP   <= 1'b1;
                    end
                end
                S_LATCH: begin
                    POP        <= 1'b0;
                    cfeb_lat   <= DAVSOUT[5:1];
                    tmb_lat    <= DAVSOUT[0];
                    alct_lat   <= DAVSOUT[16];
                    movlp_lat  <= |DAVSOUT[10:6];
                    bx_lat     <= BXCOUNTOUT;
                    cfebbx_lat <= CFEBBX;
                    l1a_cnt    <= l1a_inc;
                    l1a_lat    <= l1a_inc;
                    hdr_data   <= {4'h9, l1a_inc[11:0]};
                    hdr_dv     <= 1'b1;
                    state      <= S_H1;
                end
                S_H1: begin
                    if (hdr.HDR_RDY) begin
                        hdr_data <= {4'h9, l1a_lat[23:12]};
                        state    <= S_H2;
                    end
                end
                S_H2: begin
                    if (hdr.HDR_RDY) begin
                        hdr_data <= {cfebbx_lat, bx_lat};
                        state    <= S_H3;
                    end
                end
                S_H3: begin
                    if (hdr.HDR_RDY) begin
                        hdr_data <= {4'hB, 2'b00, alct_lat, tmb_lat, movlp_lat, cfeb_lat, 2'b00};
                        hdr_last <= 1'b1;
                        state    <= S_H4;
                    end
                end
                S_H4: begin
                    if (hdr.HDR_RDY) begin
                        hdr_data <= '0;
                        hdr_dv   <= 1'b0;
                        hdr_last <= 1'b0;
                        if (alct_lat || tmb_lat || (|cfeb_lat)) begin
                            CFEB_RDEN <= cfeb_lat;
                            TMB_RDEN  <= tmb_lat;
                            ALCT_RDEN <= alct_lat;
                            tcnt      <= '0;
                            state     <= S_PAYLOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_PAYLOAD: begin
                    // PAYDONE takes priority over a coincident timeout.
                    if (PAYDONE || (tcnt == TOUT_LIM)) begin
                        TOUT      <= TOUT | ~PAYDONE;
                        CFEB_RDEN <= '0;
                        TMB_RDEN  <= 1'b0;
                        ALCT_RDEN <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 12'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign hdr.HDR_DATA = hdr_data;
    assign hdr.HDR_DV   = hdr_dv;
    assign hdr.HDR_LAST = hdr_last;
    assign BUSY         = (state != S_IDLE);
    assign L1ACNT       = l1a_cnt;

endmodule

// File: tb/tb_gtrg_hdr_seq.sv
// Scoreboard bench for gtrg_hdr_seq: directed events push expected header
// words; a negedge monitor compares every presented word against the queue head.
module tb_gtrg_hdr_seq;

    localparam int unsigned TOUT_T = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        L1ARST;
    logic        EMPTY_B;
    logic [16:0] DAVSOUT;
    logic [11:0] BXCOUNTOUT;
    logic [3:0]  CFEBBX;
    logic        PAYDONE;
    logic        POP;
    logic [4:0]  CFEB_RDEN;
    logic        TMB_RDEN;
    logic        ALCT_RDEN;
    logic        BUSY;
    logic [23:0] L1ACNT;
    logic        TOUT;

    gtrg_hdr_seq_if hdr_bus ();

    gtrg_hdr_seq #(.L1CNT_W(24), .TOUT_CYC(TOUT_T)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .L1ARST     (L1ARST),
        .EMPTY_B    (EMPTY_B),
        .DAVSOUT    (DAVSOUT),
        .BXCOUNTOUT (BXCOUNTOUT),
        .CFEBBX     (CFEBBX),
        .hdr        (hdr_bus),
        .PAYDONE    (PAYDONE),
        .POP        (POP),
        .CFEB_RDEN  (CFEB_RDEN),
        .TMB_RDEN   (TMB_RDEN),
        .ALCT_RDEN  (ALCT_RDEN),
        .BUSY       (BUSY),
        .L1ACNT     (L1ACNT),
        .TOUT       (TOUT)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pop_cnt = 0;
    int          n_events = 0;
    logic [16:0] sb[$];
    logic [23:0] exp_cnt = '0;
    logic        exp_tout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a word is presented it must match the queue head;
    // the head retires only when the word is accepted.
    initial begin
        forever begin
            @(negedge CLK);
            if (POP === 1'b1) pop_cnt++;
            if (hdr_bus.HDR_DV === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL hdr_extra: got word 0x%0h with nothing expected at %0t",
                             hdr_bus.HDR_DATA, $time);
                end else begin
                    check("hdr_word", {15'd0, hdr_bus.HDR_LAST, hdr_bus.HDR_DATA}, {15'd0, sb[0]});
                    if (hdr_bus.HDR_RDY === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pop"},  {31'd0, POP}, 32'd0);
        check({tag, "_dv"},   {31'd0, hdr_bus.HDR_DV}, 32'd0);
        check({tag, "_data"}, {16'd0, hdr_bus.HDR_DATA}, 32'd0);
        check({tag, "_last"}, {31'd0, hdr_bus.HDR_LAST}, 32'd0);
        check({tag, "_rden"}, {25'd0, ALCT_RDEN, TMB_RDEN, CFEB_RDEN}, 32'd0);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_cnt"},  {8'd0, L1ACNT}, 32'd0);
        check({tag, "_tout"}, {31'd0, TOUT}, 32'd0);
    endtask

    // Present one FIFO entry, push its expected header, wait for the pop.
    // Returns 1 ns after the latch edge (header word 1 on the bus).
    task automatic start_event(input logic [16:0] dav, input logic [11:0] bx,
                               input logic [3:0] cbx, input logic [15:0] h4, input bit arst);
        int n;
        exp_cnt = arst ? 24'd0 : exp_cnt + 24'd1;
        sb.push_back({1'b0, 4'h9, exp_cnt[11:0]});
        sb.push_back({1'b0, 4'h9, exp_cnt[23:12]});
        sb.push_back({1'b0, cbx, bx});
        sb.push_back({1'b1, h4});
        n_events++;
        DAVSOUT    = dav;
        BXCOUNTOUT = bx;
        CFEBBX     = cbx;
        EMPTY_B    = 1'b1;
        n = 0;
        @(negedge CLK);
        while (POP !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("pop_seen", {31'd0, POP}, 32'd1);
        if (arst) L1ARST = 1'b1;
        @(posedge CLK);
        #1;
        L1ARST     = 1'b0;
        EMPTY_B    = 1'b0;
        DAVSOUT    = ~dav;
        BXCOUNTOUT = ~bx;
        CFEBBX     = ~cbx;
        check("pop_pulse", {31'd0, POP}, 32'd0);
    endtask

    task automatic run_event(input logic [16:0] dav, input logic [11:0] bx, input logic [3:0] cbx,
                             input logic [15:0] h4, input logic [6:0] rden, input int pd_delay,
                             input int bp_cycles, input bit arst);
        int n;
        start_event(dav, bx, cbx, h4, arst);
        if (bp_cycles > 0) begin
            @(posedge CLK);
            #1;
            hdr_bus.HDR_RDY = 1'b0;
            repeat (bp_cycles) begin
                @(posedge CLK);
                #1;
            end
            hdr_bus.HDR_RDY = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("hdr_done", sb.size(), 32'd0);
        check("after_hdr_busy", {31'd0, BUSY}, {31'd0, (rden != 7'd0)});
        check("rden", {25'd0, ALCT_RDEN, TMB_RDEN, CFEB_RDEN}, {25'd0, rden});
        if (rden != 7'd0) begin
            if (pd_delay >= 0) begin
                repeat (pd_delay) begin
                    @(posedge CLK);
                    #1;
                end
                PAYDONE = 1'b1;
                @(posedge CLK);
                #1;
                PAYDONE = 1'b0;
                check("paydone_exit", {31'd0, BUSY}, 32'd0);
            end else begin
                n = 0;
                do begin
                    @(posedge CLK);
                    #1;
                    n++;
                end while (BUSY && n < 40);
                check("tout_cycles", n, TOUT_T + 1);
                exp_tout = 1'b1;
            end
            check("rden_drop", {25'd0, ALCT_RDEN, TMB_RDEN, CFEB_RDEN}, 32'd0);
        end
        check("l1acnt", {8'd0, L1ACNT}, {8'd0, exp_cnt});
        check("tout", {31'd0, TOUT}, {31'd0, exp_tout});
    endtask

    initial begin
        RST             = 1'b1;
        L1ARST          = 1'b0;
        EMPTY_B         = 1'b0;
        DAVSOUT         = '0;
        BXCOUNTOUT      = '0;
        CFEBBX          = '0;
        PAYDONE         = 1'b0;
        hdr_bus.HDR_RDY = 1'b1;
        #1;
        check_idle_outputs("reset");
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // dav, bx, cfebbx, hand-computed H4, {alct,tmb,cfeb}, paydone delay, backpressure, l1arst
        run_event(17'h10006, 12'h123, 4'h5, 16'hB20C, 7'b1_0_00011, 2, 0, 1'b0);
        run_event(17'h00000, 12'hABC, 4'hE, 16'hB000, 7'b0_0_00000, 0, 0, 1'b0);
        run_event(17'h00041, 12'h7A5, 4'h3, 16'hB180, 7'b0_1_00000, 1, 0, 1'b0);
        run_event(17'h0003E, 12'h456, 4'h7, 16'hB07C, 7'b0_0_11111, 3, 3, 1'b0);
        // PAYDONE arriving on the timeout cycle must not set TOUT
        run_event(17'h00002, 12'h001, 4'h0, 16'hB004, 7'b0_0_00001, TOUT_T, 0, 1'b0);
        run_event(17'h10000, 12'hFFF, 4'hF, 16'hB200, 7'b1_0_00000, -1, 0, 1'b0);
        run_event(17'h00001, 12'h010, 4'h1, 16'hB100, 7'b0_1_00000, 2, 0, 1'b0);

        force dut.l1a_cnt = 24'hFFFFFF;
        @(negedge CLK);
        release dut.l1a_cnt;
        exp_cnt = 24'hFFFFFF;
        @(posedge CLK);
        #1;
        run_event(17'h00000, 12'h000, 4'h0, 16'hB000, 7'b0_0_00000, 0, 0, 1'b0);
        run_event(17'h007C0, 12'h321, 4'h2, 16'hB080, 7'b0_0_00000, 0, 0, 1'b0);
        run_event(17'h00000, 12'h654, 4'h9, 16'hB000, 7'b0_0_00000, 0, 0, 1'b1);

        // Reset while word 3 is on the bus
        start_event(17'h10006, 12'h123, 4'h5, 16'hB20C, 1'b0);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        sb.delete();
        exp_cnt  = '0;
        exp_tout = 1'b0;
        check_idle_outputs("midrst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        run_event(17'h00004, 12'h0F0, 4'hC, 16'hB008, 7'b0_0_00010, 2, 0, 1'b0);

        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("pop_total", pop_cnt, n_events);
        check("end_busy", {31'd0, BUSY}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
